// File: rtl/axi_lite_read_master_if.sv
// Bus bundle for the AXI-Lite read initiator: user command, AR/R channels, response
// port and status. The master modport is the initiator's view.
interface axi_lite_read_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_last;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        output axi_araddr, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rvalid,
        output axi_rready,
        output rsp_data, rsp_addr, rsp_last, rsp_valid,
        input  rsp_ready,
        output busy, timeout_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        input  axi_araddr, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rvalid,
        input  axi_rready,
        input  rsp_data, rsp_addr, rsp_last, rsp_valid,
        output rsp_ready,
        input  busy, timeout_err
    );
endinterface

// File: rtl/axi_lite_read_master.sv
// AXI-Lite read initiator: expands (addr, len) into single-beat reads of consecutive
// addresses, one outstanding at a time, with a per-phase timeout on AR and R.
module axi_lite_read_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_STRIDE    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                    axi_aclk,
    input logic                    axi_areset,
    axi_lite_read_master_if.master bus
);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RSP} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  terr_q, terr_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  expire;

    // Expiry means this is the TIMEOUT_CYCLES-th consecutive cycle without a handshake.
    assign expire = (TIMEOUT_CYCLES != 0) && (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            terr_q     <= 1'b0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
            terr_q     <= terr_d;
            tmr_q      <= tmr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_last_d = rsp_last_q;
        terr_d     = 1'b0;
        tmr_d      = tmr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d  = bus.cmd_addr;
                    rem_d   = bus.cmd_len;
                    tmr_d   = '0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                // Handshake is checked first so it wins over a same-cycle expiry.
                if (bus.axi_arready) begin
                    tmr_d   = '0;
                    state_d = S_R;
                end else if (expire) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_R: begin
                if (bus.axi_rvalid) begin
                    rsp_data_d = bus.axi_rdata;
                    rsp_addr_d = addr_q;
                    rsp_last_d = (rem_q == '0);
                    state_d    = S_RSP;
                end else if (expire) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
                        rem_d   = rem_q - 1'b1;
                        tmr_d   = '0;
                        state_d = S_AR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register, so they never
    // depend combinationally on the partner's ready/valid.
    assign bus.cmd_ready   = (state_q == S_IDLE) && !axi_areset;
    assign bus.axi_arvalid = (state_q == S_AR);
    assign bus.axi_rready  = (state_q == S_R);
    assign bus.rsp_valid   = (state_q == S_RSP);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.axi_araddr  = addr_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_addr    = rsp_addr_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_axi_lite_read_master.sv
// Directed bench for axi_lite_read_master: ROM responder with programmable waits, a
// queue-based expectation model and per-cycle comparison at the falling edge.
module tb_axi_lite_read_master;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_lite_read_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_read_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_STRIDE(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_aclk  (clk),
        .axi_areset(rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] rom [16];

    // responder / user knobs
    int ar_dly  = 0;
    int r_dly   = 0;
    int rsp_dly = 0;
    bit r_never = 0;

    // observation logs, cleared by main per test
    logic [AW-1:0] ar_log[$];
    int            ar_cyc[$];
    logic [DW-1:0] rd_log[$];
    logic [AW-1:0] ra_log[$];
    logic          rl_log[$];
    int            rsp_cyc[$];
    int            terr_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // AXI-Lite ROM responder and response consumer; updates land 1 time unit after the edge.
    initial begin : responder
        int ar_cnt, r_cnt, u_cnt;
        bit pend, ar_hs, r_hs, u_hs, arv, rspv, terr;
        logic [AW-1:0] paddr, a;
        bus.axi_arready = 1'b1;
        bus.axi_rvalid  = 1'b0;
        bus.axi_rdata   = '0;
        bus.rsp_ready   = 1'b1;
        ar_cnt = 0; r_cnt = 0; u_cnt = 0; pend = 0; paddr = '0;
        forever begin
            @(negedge clk);
            ar_hs = bus.axi_arvalid && bus.axi_arready;
            r_hs  = bus.axi_rvalid && bus.axi_rready;
            u_hs  = bus.rsp_valid && bus.rsp_ready;
            arv   = bus.axi_arvalid;
            rspv  = bus.rsp_valid;
            terr  = bus.timeout_err;
            a     = bus.axi_araddr;
            @(posedge clk);
            #1;
            if (rst || terr) begin
                bus.axi_arready = (ar_dly == 0);
                bus.axi_rvalid  = 1'b0;
                bus.rsp_ready   = (rsp_dly == 0);
                ar_cnt = 0; r_cnt = 0; u_cnt = 0; pend = 0;
            end else begin
                if (ar_hs) begin
                    bus.axi_arready = (ar_dly == 0);
                    ar_cnt = 0; pend = 1; paddr = a; r_cnt = 0;
                end else if (arv && !bus.axi_arready) begin
                    ar_cnt++;
                    if (ar_cnt >= ar_dly) bus.axi_arready = 1'b1;
                end else if (!arv) begin
                    bus.axi_arready = (ar_dly == 0);
                    ar_cnt = 0;
                end
                if (r_hs) bus.axi_rvalid = 1'b0;
                if (pend && !r_never) begin
                    if (r_cnt >= r_dly) begin
                        bus.axi_rvalid = 1'b1;
                        bus.axi_rdata  = rom[paddr];
                        pend = 0;
                    end else begin
                        r_cnt++;
                    end
                end
                if (u_hs) begin
                    bus.rsp_ready = (rsp_dly == 0);
                    u_cnt = 0;
                end else if (rspv && !bus.rsp_ready) begin
                    u_cnt++;
                    if (u_cnt >= rsp_dly) bus.rsp_ready = 1'b1;
                end else if (!rspv) begin
                    bus.rsp_ready = (rsp_dly == 0);
                    u_cnt = 0;
                end
            end
        end
    end

    // Expectation model: an accepted command expands into a list of addresses and
    // ROM words; AR/R waits are counted against the timeout; every cycle is checked.
    logic [AW-1:0] exp_ar[$];
    rsp_t          exp_rsp[$];

    initial begin : compare
        bit   mb, terr_pend, terr_now, p_arwait, p_rspwait;
        int   wait_cnt;
        logic [AW-1:0] p_araddr, p_ra, a;
        logic [DW-1:0] p_rd;
        logic          p_rl;
        rsp_t          e;
        mb = 0; terr_pend = 0; p_arwait = 0; p_rspwait = 0; wait_cnt = 0;
        p_araddr = '0; p_ra = '0; p_rd = '0; p_rl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_cmd_ready", bus.cmd_ready, 0);
                chk("rst_arvalid", bus.axi_arvalid, 0);
                chk("rst_rready", bus.axi_rready, 0);
                chk("rst_rsp_valid", bus.rsp_valid, 0);
                chk("rst_rsp_last", bus.rsp_last, 0);
                chk("rst_busy", bus.busy, 0);
                chk("rst_timeout_err", bus.timeout_err, 0);
                chk("rst_araddr", bus.axi_araddr, 0);
                chk("rst_rsp_data", bus.rsp_data, 0);
                chk("rst_rsp_addr", bus.rsp_addr, 0);
                exp_ar.delete();
                exp_rsp.delete();
                mb = 0; terr_pend = 0; p_arwait = 0; p_rspwait = 0; wait_cnt = 0;
            end else begin
                chk("busy", bus.busy, mb);
                chk("cmd_ready", bus.cmd_ready, !mb);
                chk("timeout_err", bus.timeout_err, terr_pend);
                if (bus.timeout_err) terr_cyc.push_back(cyc);
                if (p_arwait && !terr_pend) begin
                    chk("ar_hold_valid", bus.axi_arvalid, 1);
                    chk("ar_hold_addr", bus.axi_araddr, p_araddr);
                end
                if (p_rspwait) begin
                    chk("rsp_hold_valid", bus.rsp_valid, 1);
                    chk("rsp_hold_data", bus.rsp_data, p_rd);
                    chk("rsp_hold_addr", bus.rsp_addr, p_ra);
                    chk("rsp_hold_last", bus.rsp_last, p_rl);
                end
                if (bus.rsp_valid && exp_rsp.size() == 0) fail_now("rsp_valid_unexpected");

                if (bus.axi_arvalid && bus.axi_arready) begin
                    ar_log.push_back(bus.axi_araddr);
                    ar_cyc.push_back(cyc);
                    if (exp_ar.size() == 0) fail_now("ar_unexpected");
                    else chk("araddr", bus.axi_araddr, exp_ar.pop_front());
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    rd_log.push_back(bus.rsp_data);
                    ra_log.push_back(bus.rsp_addr);
                    rl_log.push_back(bus.rsp_last);
                    rsp_cyc.push_back(cyc);
                    if (exp_rsp.size() != 0) begin
                        e = exp_rsp.pop_front();
                        chk("rsp_data", bus.rsp_data, e.d);
                        chk("rsp_addr", bus.rsp_addr, e.a);
                        chk("rsp_last", bus.rsp_last, e.l);
                        if (e.l) mb = 0;
                    end
                end

                terr_now = 0;
                if ((bus.axi_arvalid && !bus.axi_arready) || (bus.axi_rready && !bus.axi_rvalid)) begin
                    wait_cnt++;
                    if (wait_cnt == TO) begin
                        terr_now = 1;
                        exp_ar.delete();
                        exp_rsp.delete();
                        mb = 0;
                        wait_cnt = 0;
                    end
                end else begin
                    wait_cnt = 0;
                end
                terr_pend = terr_now;

                if (bus.cmd_valid && bus.cmd_ready) begin
                    for (int i = 0; i <= int'(bus.cmd_len); i++) begin
                        a = AW'(int'(bus.cmd_addr) + i);
                        exp_ar.push_back(a);
                        e.d = rom[a];
                        e.a = a;
                        e.l = (i == int'(bus.cmd_len));
                        exp_rsp.push_back(e);
                    end
                    mb = 1;
                end

                p_arwait  = bus.axi_arvalid && !bus.axi_arready;
                p_araddr  = bus.axi_araddr;
                p_rspwait = bus.rsp_valid && !bus.rsp_ready;
                p_rd      = bus.rsp_data;
                p_ra      = bus.rsp_addr;
                p_rl      = bus.rsp_last;
            end
        end
    end

    task automatic clear_logs();
        ar_log.delete(); ar_cyc.delete(); rd_log.delete(); ra_log.delete();
        rl_log.delete(); rsp_cyc.delete(); terr_cyc.delete();
    endtask

    task automatic do_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
        int  n;
        bit  hs;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        n = 0;
        do begin
            @(negedge clk);
            hs = bus.cmd_ready;
            n++;
        end while (!hs && n < 50);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (!hs) fail_now("cmd_accept_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 400);
        if (bus.busy) fail_now("wait_idle_timeout");
    endtask

    initial begin : main
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        rom[0] = 32'hAAAAAAAA;
        rom[1] = 32'h55555555;
        rom[2] = 32'h00000000;
        for (int i = 3; i < 16; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h111;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single read
        clear_logs();
        do_cmd(4'd1, 4'd0);
        wait_idle();
        chk("t1_ar_count", ar_log.size(), 1);
        chk("t1_araddr", ar_log[0], 1);
        chk("t1_rsp_count", rd_log.size(), 1);
        chk("t1_rsp_data", rd_log[0], 32'h55555555);
        chk("t1_rsp_addr", ra_log[0], 1);
        chk("t1_rsp_last", rl_log[0], 1);

        // three-word burst at zero wait: one response every 3 cycles
        clear_logs();
        do_cmd(4'd0, 4'd2);
        wait_idle();
        chk("t2_rsp_count", rd_log.size(), 3);
        chk("t2_d0", rd_log[0], 32'hAAAAAAAA);
        chk("t2_d1", rd_log[1], 32'h55555555);
        chk("t2_d2", rd_log[2], 32'h00000000);
        chk("t2_a2", ra_log[2], 2);
        chk("t2_last", {rl_log[0], rl_log[1], rl_log[2]}, 3'b001);
        chk("t2_gap01", rsp_cyc[1] - rsp_cyc[0], 3);
        chk("t2_gap12", rsp_cyc[2] - rsp_cyc[1], 3);

        // address wrap 14,15,0,1
        clear_logs();
        do_cmd(4'd14, 4'd3);
        wait_idle();
        chk("t3_ar_count", ar_log.size(), 4);
        chk("t3_araddr", {ar_log[0], ar_log[1], ar_log[2], ar_log[3]}, 16'hEF01);
        chk("t3_rsp_addr", {ra_log[0], ra_log[1], ra_log[2], ra_log[3]}, 16'hEF01);
        chk("t3_d2", rd_log[2], 32'hAAAAAAAA);

        // backpressure: 5 AR waits, 3 R waits, 4 RSP waits -> 6+4+5 cycles per word
        clear_logs();
        ar_dly = 5; r_dly = 3; rsp_dly = 4;
        do_cmd(4'd3, 4'd1);
        wait_idle();
        chk("t4_ar_count", ar_log.size(), 2);
        chk("t4_rsp_count", rd_log.size(), 2);
        chk("t4_d1", rd_log[1], 32'h10000444);
        chk("t4_gap", rsp_cyc[1] - rsp_cyc[0], 15);
        ar_dly = 0; r_dly = 0; rsp_dly = 0;

        // timeout: pulse is registered on the 8th edge after the AR handshake edge
        clear_logs();
        r_never = 1;
        do_cmd(4'd2, 4'd0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("t5_terr_count", terr_cyc.size(), 1);
        chk("t5_terr_delay", terr_cyc[0] - ar_cyc[0], 9);
        chk("t5_rsp_count", rd_log.size(), 0);
        chk("t5_rready", bus.axi_rready, 0);
        chk("t5_cmd_ready", bus.cmd_ready, 1);
        r_never = 0;

        // reset during R of word 2 of 4, then a fresh single read
        clear_logs();
        r_dly = 3;
        do_cmd(4'd4, 4'd3);
        begin
            int n;
            n = 0;
            while (ar_log.size() < 2 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (ar_log.size() < 2) fail_now("t6_second_ar_timeout");
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_rready", bus.axi_rready, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_cmd_ready", bus.cmd_ready, 0);
        chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r_dly = 0;
        clear_logs();
        do_cmd(4'd5, 4'd0);
        wait_idle();
        chk("t6_rsp_count", rd_log.size(), 1);
        chk("t6_rsp_data", rd_log[0], 32'h10000555);
        chk("t6_rsp_addr", ra_log[0], 5);
        chk("t6_terr_count", terr_cyc.size(), 0);
        chk("sb_rsp_empty", exp_rsp.size(), 0);
        chk("sb_ar_empty", exp_ar.size(), 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout at t=%0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end
endmodule
